spi_controller: RTL and testbench

- SPI mode-0 controller that drives 16-bit frames into the onboarding SPI peripheral, the register-write path that feeds the PWM/output-enable registers.
- Converts a single-cycle command (rw, 7-bit address, 8-bit data) into nCS/SCLK/COPI waveforms and captures CIPO during the data byte.
- Used as a bench/bring-up master and as an on-chip configuration sequencer.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_gen.sv | 22 ++
 rtl/sync_2ff.sv | 13 +
 rtl/spi_controller.sv | 73 +++++++
 tb/tb_spi_controller.sv | 138 +++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, frame layout and peripheral register map
// for the SPI mode-0 register-write controller.
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;

    localparam logic [6:0] REG_OUT_EN_LO = 7'h00;
    localparam logic [6:0] REG_OUT_EN_HI = 7'h01;
    localparam logic [6:0] REG_PWM_EN_LO = 7'h02;
    localparam logic [6:0] REG_PWM_EN_HI = 7'h03;
    localparam logic [6:0] REG_DUTY      = 7'h04;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter; strike marks the last cycle of each
// CLK_DIV-cycle interval while enabled.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic strike
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign strike = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst)
        if (rst)                cnt <= '0;
        else if (!en || strike) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
endmodule

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for a single asynchronous input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 master sending {rw, addr, wdata} frames MSB
// first and capturing CIPO during the data byte.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       copi,
    input  logic       cipo,
    output logic       ncs
);
    import spi_pkg::*;

    state_t                  state, state_n;
    logic                    strike, cipo_sync;
    logic [FRAME_BITS-1:0]   frame;
    logic [4:0]              halves;
    logic [7:0]              rdata_shift;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk(clk), .rst(rst), .en(state != IDLE), .strike(strike)
    );

    sync_2ff u_sync (.clk(clk), .rst(rst), .d(cipo), .q(cipo_sync));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SETUP : IDLE;
            SETUP:   state_n = strike ? SHIFT : SETUP;
            SHIFT:   state_n = (strike && halves == 5'd31) ? HOLD : SHIFT;
            HOLD:    state_n = strike ? GAP : HOLD;
            GAP:     state_n = strike ? IDLE : GAP;
            default: state_n = IDLE;
        endcase
        busy = state != IDLE;
        ncs  = !(state == SETUP || state == SHIFT || state == HOLD);
        copi = frame[RW_BIT];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            frame       <= '0;
            halves      <= '0;
            sclk        <= 1'b0;
            rdata_shift <= '0;
            rdata       <= '0;
            done        <= 1'b0;
        end else begin
            state <= state_n;
            done  <= state == GAP && strike;
            if (state == IDLE && start)
                frame <= {rw, addr[ADDR_MSB-ADDR_LSB:0], wdata[DATA_MSB:0]};
            if (state == GAP && strike)
                rdata <= rdata_shift;
            // Sample on the rising strike, advance COPI on the falling one.
            if (state == SHIFT && strike) begin
                halves <= halves + 1'b1;
                sclk   <= ~sclk;
                if (sclk) frame       <= {frame[FRAME_BITS-2:0], 1'b0};
                else      rdata_shift <= {rdata_shift[6:0], cipo_sync};
            end
        end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: randomized frames on a CLK_DIV=4 and a CLK_DIV=2
// instance, checked against frame-level timing and content expectations.
module tb_spi_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, start, rw, busy, done, sclk, copi, cipo, ncs;
    logic [6:0] addr [2];
    logic [7:0] wdata [2];
    logic [7:0] rdata [2];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_controller #(.CLK_DIV(g == 0 ? 4 : 2)) dut (
            .clk(clk), .rst(rst[g]), .start(start[g]), .rw(rw[g]),
            .addr(addr[g]), .wdata(wdata[g]), .busy(busy[g]), .done(done[g]),
            .rdata(rdata[g]), .sclk(sclk[g]), .copi(copi[g]), .cipo(cipo[g]),
            .ncs(ncs[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one frame from the current negedge; returns on the done negedge
    // so a following call exercises back-to-back starts.
    task automatic frame(input int u, input logic f_rw, input logic [6:0] f_addr,
                         input logic [7:0] f_data, input logic [7:0] pat,
                         input int poke, input int abort);
        int div = (u == 0) ? 4 : 2;
        logic [15:0] got_frame = '0;
        logic [7:0] old_rdata = rdata[u];
        int rises = 0, falls = 0, busy_n = 0, low_n = 0, gap_n = 0, done_k = 0, rd_changes = 0;
        logic prev_sclk = 1'b0, was_low = 1'b0;
        start[u] = 1'b1; rw[u] = f_rw; addr[u] = f_addr; wdata[u] = f_data;
        @(negedge clk);
        start[u] = 1'b0; rw[u] = 1'($urandom); addr[u] = 7'($urandom); wdata[u] = 8'($urandom);
        for (int k = 1; k <= 40 * div; k++) begin
            if (k == abort) begin
                rst[u] = 1'b1;
                #1;
                chk("abort_ncs", 32'(ncs[u]), 1);
                chk("abort_sclk", 32'(sclk[u]), 0);
                chk("abort_busy", 32'(busy[u]), 0);
                chk("abort_rdata", 32'(rdata[u]), 0);
                @(negedge clk);
                rst[u] = 1'b0; cipo[u] = 1'b0;
                repeat (40 * div) begin
                    @(negedge clk);
                    if (done[u] || !ncs[u]) break;
                end
                chk("abort_no_done", 32'(done[u]), 0);
                chk("abort_idle_ncs", 32'(ncs[u]), 1);
                return;
            end
            if (k == poke) begin
                start[u] = 1'b1; rw[u] = ~f_rw; addr[u] = ~f_addr; wdata[u] = ~f_data;
            end
            if (k == poke + 1) start[u] = 1'b0;
            if (k == 1) begin
                chk("setup_ncs", 32'(ncs[u]), 0);
                chk("setup_sclk", 32'(sclk[u]), 0);
                chk("setup_copi", 32'(copi[u]), 32'(f_rw));
            end
            if (sclk[u] && !prev_sclk) begin
                got_frame = {got_frame[14:0], copi[u]};
                rises++;
            end
            if (!sclk[u] && prev_sclk) begin
                falls++;
                cipo[u] = (falls >= 8 && falls <= 15) ? pat[15 - falls] : 1'b0;
            end
            prev_sclk = sclk[u];
            busy_n += int'(busy[u]);
            if (!ncs[u]) begin
                low_n++;
                was_low = 1'b1;
            end else if (was_low && busy[u]) gap_n++;
            if (done[u]) begin
                done_k = k;
                break;
            end
            if (rdata[u] !== old_rdata) rd_changes++;
            @(negedge clk);
        end
        cipo[u] = 1'b0;
        chk("done_latency", 32'(done_k), 32'(35 * div + 1));
        chk("copi_frame", 32'(got_frame), 32'({f_rw, f_addr, f_data}));
        chk("sclk_pulses", 32'(rises), 16);
        chk("busy_cycles", 32'(busy_n), 32'(35 * div));
        chk("ncs_low_cycles", 32'(low_n), 32'(34 * div));
        chk("ncs_gap_cycles", 32'(gap_n), 32'(div));
        chk("rdata", 32'(rdata[u]), 32'(pat));
        chk("rdata_early", 32'(rd_changes), 0);
    endtask

    initial begin
        rst = 2'b11; start = '0; rw = '0; cipo = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 2'b00;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ncs", 32'(ncs[i]), 1);
            chk("reset_sclk", 32'(sclk[i]), 0);
            chk("reset_copi", 32'(copi[i]), 0);
            chk("reset_busy", 32'(busy[i]), 0);
            chk("reset_done", 32'(done[i]), 0);
            chk("reset_rdata", 32'(rdata[i]), 0);
        end
        frame(0, 1'b1, 7'h00, 8'hF0, 8'h00, 0, 0);
        frame(0, 1'b1, 7'h04, 8'h80, 8'h00, 0, 0);
        frame(0, 1'b0, 7'h02, 8'h00, 8'hA5, 0, 0);
        frame(0, 1'b1, 7'h03, 8'h5A, 8'h3C, 50, 0);
        frame(0, 1'b0, 7'h01, 8'h77, 8'hC3, 0, 73);
        frame(0, 1'b1, 7'h04, 8'h99, 8'h00, 0, 0);
        repeat (6) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            frame(0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 0, 0);
        end
        frame(1, 1'b1, 7'h00, 8'h00, 8'h00, 0, 0);
        frame(1, 1'b1, 7'h01, 8'hFF, 8'h00, 0, 0);
        repeat (4) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            frame(1, 1'($urandom), 7'($urandom), 8'($urandom), 8'h00, 0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
